// File: rtl/led_chaser_pkg.sv
// led_chaser_pkg: pattern modes and the LED decode helper shared by the chaser.
package led_chaser_pkg;
    typedef enum logic [1:0] {MODE_ROT_UP, MODE_ROT_DN, MODE_BOUNCE, MODE_FILL} mode_t;
    localparam int unsigned MAX_LEDS = 64;
    // One-hot or thermometer pattern for position p; positions outside the bank light nothing.
    function automatic logic [MAX_LEDS-1:0] decode(input int unsigned p, input int unsigned n, input mode_t m);
        logic [MAX_LEDS-1:0] d;
        for (int unsigned i = 0; i < MAX_LEDS; i++)
            d[i] = (p < n) && ((m == MODE_FILL) ? (i <= p) : (i == p));
        return d;
    endfunction
endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: emits a one-cycle tick every TICK_DIV enabled cycles.
module tick_prescaler #(
    parameter int unsigned TICK_DIV = 25000000
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);
    localparam int unsigned CW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    logic [CW-1:0] count;
    assign tick = en && count == CW'(TICK_DIV - 1);
    always_ff @(posedge clk or posedge reset)
        if (reset) count <= '0;
        else if (clr || tick) count <= '0;
        else if (en) count <= count + 1'b1;
endmodule

// File: rtl/led_chaser.sv
// led_chaser: prescaled LED sequencer with rotate, bounce and fill patterns.
module led_chaser
    import led_chaser_pkg::*;
#(
    parameter int unsigned N_LEDS   = 4,
    parameter int unsigned TICK_DIV = 25000000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      en,
    input  logic [1:0]                mode,
    input  logic                      restart,
    input  logic                      blank,
    output logic [N_LEDS-1:0]         leds,
    output logic [$clog2(N_LEDS)-1:0] pos,
    output logic                      step
);
    localparam int unsigned PW = $clog2(N_LEDS);
    localparam logic [PW-1:0] LAST = PW'(N_LEDS - 1);
    if (N_LEDS < 2 || N_LEDS > MAX_LEDS) begin : g_bad_leds
        $error("led_chaser: N_LEDS out of range");
    end
    if (TICK_DIV < 1) begin : g_bad_div
        $error("led_chaser: TICK_DIV must be at least 1");
    end
    logic          tick;
    logic          dir_up;
    logic          dir_up_n;
    logic          step_n;
    logic          oob;
    logic [PW-1:0] pos_n;
    mode_t         mode_q;
    mode_t         mode_q_n;
    mode_t         mode_in;
    tick_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .clr   (restart),
        .tick  (tick)
    );
    always_comb begin
        mode_in  = mode_t'(mode);
        oob      = 32'(pos) >= N_LEDS;
        pos_n    = pos;
        dir_up_n = dir_up;
        mode_q_n = mode_q;
        step_n   = 1'b0;
        if (restart) begin
            pos_n    = '0;
            dir_up_n = 1'b1;
            mode_q_n = mode_in;
        end else if (tick) begin
            mode_q_n = mode_in;
            step_n   = 1'b1;
            // Bounce turns around at either end; the new direction then decides the move.
            dir_up_n = mode_in == MODE_ROT_DN ? 1'b0 :
                       mode_in == MODE_BOUNCE ? (dir_up ? pos != LAST : pos == '0) : 1'b1;
            pos_n    = oob ? '0 :
                       mode_in == MODE_ROT_DN ? (pos == '0 ? LAST : pos - 1'b1) :
                       mode_in == MODE_BOUNCE ? (dir_up_n ? pos + 1'b1 : pos - 1'b1) :
                       (pos == LAST ? '0 : pos + 1'b1);
        end
    end
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            pos    <= '0;
            dir_up <= 1'b1;
            mode_q <= MODE_ROT_UP;
            leds   <= N_LEDS'(1);
            step   <= 1'b0;
        end else begin
            pos    <= pos_n;
            dir_up <= dir_up_n;
            mode_q <= mode_q_n;
            leds   <= blank ? '0 : N_LEDS'(decode(32'(pos_n), N_LEDS, mode_q_n));
            step   <= step_n;
        end
endmodule

// File: tb/tb_led_chaser.sv
// tb_led_chaser: directed and random stimulus against a cycle model, checked through a scoreboard.
module tb_led_chaser;
    logic       clk = 0, reset = 0, en = 0, restart = 0, blank = 0;
    logic [1:0] mode = 0;
    logic [3:0] leds;
    logic [1:0] pos;
    logic       step;
    int total = 0, bad = 0;
    typedef struct {logic [3:0] leds; logic [1:0] pos; logic step;} exp_t;
    exp_t sb[$];
    int steps[$];
    int m_cnt, m_pos, m_up, m_mq;
    always #5 clk = ~clk;
    led_chaser #(.N_LEDS(4), .TICK_DIV(4)) dut (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .restart(restart),
        .blank(blank), .leds(leds), .pos(pos), .step(step)
    );
    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask
    task automatic model_reset();
        m_cnt = 0; m_pos = 0; m_up = 1; m_mq = 0;
    endtask
    task automatic cyc(input logic e, input logic [1:0] md, input logic rs, input logic bl);
        exp_t x, y;
        en = e; mode = md; restart = rs; blank = bl;
        x.step = 0;
        if (rs) begin
            m_cnt = 0; m_pos = 0; m_up = 1; m_mq = md;
        end else if (e && m_cnt == 3) begin
            m_cnt = 0; m_mq = md; x.step = 1;
            case (md)
                0, 3: begin m_pos = (m_pos + 1) % 4; m_up = 1; end
                1: begin m_pos = (m_pos + 3) % 4; m_up = 0; end
                default:
                    if (m_up) begin
                        if (m_pos == 3) begin m_pos = 2; m_up = 0; end else m_pos++;
                    end else begin
                        if (m_pos == 0) begin m_pos = 1; m_up = 1; end else m_pos--;
                    end
            endcase
        end else if (e) m_cnt++;
        x.pos  = 2'(m_pos);
        x.leds = bl ? 4'b0 : (m_mq == 3 ? 4'((1 << (m_pos + 1)) - 1) : 4'(1 << m_pos));
        sb.push_back(x);
        @(posedge clk); #1;
        y = sb.pop_front();
        check("leds", leds, y.leds);
        check("pos", {2'b0, pos}, {2'b0, y.pos});
        check("step", {3'b0, step}, {3'b0, y.step});
        if (step) steps.push_back(int'(pos));
    endtask
    initial begin
        int bt[7] = '{1, 2, 3, 2, 1, 0, 1};
        #1 reset = 1;
        #1;
        check("rst_leds", leds, 4'b0001);
        check("rst_pos", {2'b0, pos}, 4'd0);
        check("rst_step", {3'b0, step}, 4'd0);
        model_reset();
        #5 reset = 0;
        repeat (20) cyc(1, 0, 0, 0);
        cyc(1, 2, 1, 0);
        steps.delete();
        repeat (28) cyc(1, 2, 0, 0);
        check("bounce_n", 4'(steps.size()), 4'd7);
        for (int i = 0; i < steps.size() && i < 7; i++) check("bounce_pos", 4'(steps[i]), 4'(bt[i]));
        cyc(1, 3, 1, 0);
        repeat (18) cyc(1, 3, 0, 0);
        repeat (6) cyc(1, 1, 0, 0);
        cyc(1, 0, 1, 0);
        repeat (2) cyc(1, 0, 0, 0);
        repeat (10) cyc(0, 0, 0, 0);
        repeat (4) cyc(1, 0, 0, 0);
        cyc(0, 2, 1, 0);
        cyc(1, 0, 1, 0);
        repeat (3) cyc(1, 0, 0, 0);
        cyc(1, 0, 1, 0);
        repeat (5) cyc(1, 0, 0, 0);
        repeat (3) cyc(1, 0, 0, 1);
        repeat (6) cyc(1, 0, 0, 0);
        cyc(1, 0, 1, 0);
        repeat (4) cyc(1, 0, 0, 0);
        #3 reset = 1;
        #1;
        check("arst_leds", leds, 4'b0001);
        check("arst_pos", {2'b0, pos}, 4'd0);
        check("arst_step", {3'b0, step}, 4'd0);
        model_reset();
        @(posedge clk);
        #2 reset = 0;
        repeat (8) cyc(1, 0, 0, 0);
        repeat (150) cyc($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
                         $urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
